// File: rtl/invader_pkg.sv
// Shared types and default constants for the invader row movement controller.
package invader_pkg;

  // Row movement state machine
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MARCH_R = 3'd1,
    MARCH_L = 3'd2,
    DROP    = 3'd3,
    CLEARED = 3'd4,
    LANDED  = 3'd5
  } invader_state_t;

  // Default geometry and pacing
  localparam int DEF_NUM_INVADERS    = 10;
  localparam int DEF_X_STEP          = 4;
  localparam int DEF_X_MAX           = 100;
  localparam int DEF_Y_STEP          = 16;
  localparam int DEF_Y_MAX           = 400;
  localparam int DEF_FRAMES_PER_STEP = 8;

  // Positions are 10 bits; arithmetic carries one guard bit so sums never wrap
  localparam int POS_W   = 10;
  localparam int ARITH_W = 11;

endpackage

// File: rtl/invader_popcount.sv
// Counts the set bits of a vector; used to derive the alive invader count.
module invader_popcount #(
  parameter int  WIDTH = 10,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);

  // Accumulate one bit at a time into a count wide enough for all ones
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/invader_move_ctl.sv
// Invader row movement controller: marches the row left/right once per step
// period, drops it at each edge, tracks which invaders are alive and flags a
// cleared wave or a landed row. Outputs are all registered.
// Optional build macro INVADER_SPEEDUP_EN shortens the step period as the
// row thins out (alive count from invader_popcount).
module invader_move_ctl
  import invader_pkg::*;
#(
  parameter int NUM_INVADERS    = DEF_NUM_INVADERS,
  parameter int X_STEP          = DEF_X_STEP,
  parameter int X_MAX           = DEF_X_MAX,
  parameter int Y_STEP          = DEF_Y_STEP,
  parameter int Y_MAX           = DEF_Y_MAX,
  parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
  input  logic                    clk65MHz,
  input  logic                    rst,
  input  logic                    vblnk,
  input  logic                    start,
  input  logic                    hit_valid,
  input  logic [3:0]              hit_index,
  output logic [POS_W-1:0]        xpos,
  output logic [POS_W-1:0]        ypos,
  output logic [NUM_INVADERS-1:0] invader_enable,
  output logic                    all_dead,
  output logic                    reached_bottom
);

  // Counter holds values up to FRAMES_PER_STEP so the "+1" compare never wraps
  localparam int CNT_W = $clog2(FRAMES_PER_STEP) + 1;

  invader_state_t          state_r;
  logic                    vblnk_d_r;
  logic                    tick_r;
  logic                    dir_left_r;
  logic [CNT_W-1:0]        frame_cnt_r;
  logic [POS_W-1:0]        xpos_r;
  logic [POS_W-1:0]        ypos_r;
  logic [NUM_INVADERS-1:0] enable_r;
  logic                    all_dead_r;
  logic                    reached_bottom_r;

  logic [CNT_W-1:0]        cnt_inc_s;
  logic [CNT_W-1:0]        period_s;
  logic                    step_s;
  logic [NUM_INVADERS-1:0] kill_mask_s;
  logic [NUM_INVADERS-1:0] alive_next_s;
  logic [ARITH_W-1:0]      x_inc_s;
  logic [ARITH_W-1:0]      y_inc_s;
  logic                    x_fits_s;
  logic                    x_can_dec_s;
  logic                    y_lands_s;

`ifdef INVADER_SPEEDUP_EN
  localparam int NUM_W = $clog2(NUM_INVADERS + 1);
  logic [NUM_W-1:0] alive_cnt_s;

  invader_popcount #(
    .WIDTH (NUM_INVADERS)
  ) u_popcount (
    .bits  (enable_r),
    .count (alive_cnt_s)
  );

  // Step period shrinks as the row thins: full, half, then quarter
  always_comb begin
    if (alive_cnt_s > NUM_W'(NUM_INVADERS / 2)) begin
      period_s = CNT_W'(FRAMES_PER_STEP);
    end else if (alive_cnt_s > NUM_W'(1)) begin
      period_s = CNT_W'(FRAMES_PER_STEP / 2);
    end else begin
      period_s = CNT_W'(FRAMES_PER_STEP / 4);
    end
  end
`else
  assign period_s = CNT_W'(FRAMES_PER_STEP);
`endif

  // Decode a hit into a one-hot kill mask; out-of-range indices match nothing
  always_comb begin
    kill_mask_s = '0;
    for (int i = 0; i < NUM_INVADERS; i++) begin
      if (hit_valid && (int'(hit_index) == i)) begin
        kill_mask_s[i] = 1'b1;
      end else begin
        kill_mask_s[i] = 1'b0;
      end
    end
  end

  assign alive_next_s = enable_r & ~kill_mask_s;
  assign cnt_inc_s    = frame_cnt_r + CNT_W'(1);
  // ">=" lets a freshly shortened period fire on the very next tick
  assign step_s       = tick_r && (cnt_inc_s >= period_s);
  assign x_inc_s      = {1'b0, xpos_r} + ARITH_W'(X_STEP);
  assign y_inc_s      = {1'b0, ypos_r} + ARITH_W'(Y_STEP);
  assign x_fits_s     = (x_inc_s <= ARITH_W'(X_MAX));
  assign x_can_dec_s  = ({1'b0, xpos_r} >= ARITH_W'(X_STEP));
  assign y_lands_s    = (y_inc_s >= ARITH_W'(Y_MAX));

  // Frame tick edge detect, movement state machine and all output registers
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_r          <= IDLE;
      vblnk_d_r        <= 1'b0;
      tick_r           <= 1'b0;
      dir_left_r       <= 1'b0;
      frame_cnt_r      <= '0;
      xpos_r           <= '0;
      ypos_r           <= '0;
      enable_r         <= '0;
      all_dead_r       <= 1'b0;
      reached_bottom_r <= 1'b0;
    end else begin
      vblnk_d_r <= vblnk;
      tick_r    <= vblnk & ~vblnk_d_r;
      case (state_r)
        IDLE, CLEARED, LANDED: begin
          frame_cnt_r <= '0;
          if (start) begin
            state_r          <= MARCH_R;
            xpos_r           <= '0;
            ypos_r           <= '0;
            enable_r         <= '1;
            all_dead_r       <= 1'b0;
            reached_bottom_r <= 1'b0;
            dir_left_r       <= 1'b0;
          end else begin
            enable_r <= alive_next_s;
          end
        end
        MARCH_R, MARCH_L, DROP: begin
          enable_r <= alive_next_s;
          if (step_s) begin
            frame_cnt_r <= '0;
          end else if (tick_r) begin
            frame_cnt_r <= cnt_inc_s;
          end else begin
            frame_cnt_r <= frame_cnt_r;
          end
          if (step_s) begin
            case (state_r)
              MARCH_R: begin
                if (x_fits_s) begin
                  xpos_r <= x_inc_s[POS_W-1:0];
                end else begin
                  xpos_r     <= POS_W'(X_MAX);
                  state_r    <= DROP;
                  dir_left_r <= 1'b1;
                end
              end
              MARCH_L: begin
                if (x_can_dec_s) begin
                  xpos_r <= xpos_r - POS_W'(X_STEP);
                end else begin
                  xpos_r     <= '0;
                  state_r    <= DROP;
                  dir_left_r <= 1'b0;
                end
              end
              DROP: begin
                if (y_lands_s) begin
                  ypos_r           <= POS_W'(Y_MAX);
                  state_r          <= LANDED;
                  // A wave cleared in the same cycle wins over the landing
                  reached_bottom_r <= (alive_next_s != '0);
                end else begin
                  ypos_r  <= y_inc_s[POS_W-1:0];
                  state_r <= dir_left_r ? MARCH_L : MARCH_R;
                end
              end
              default: state_r <= IDLE;
            endcase
          end
          // Last invader gone overrides whatever the step chose
          if (alive_next_s == '0) begin
            state_r    <= CLEARED;
            all_dead_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          frame_cnt_r <= '0;
        end
      endcase
    end
  end

  assign xpos           = xpos_r;
  assign ypos           = ypos_r;
  assign invader_enable = enable_r;
  assign all_dead       = all_dead_r;
  assign reached_bottom = reached_bottom_r;

endmodule

// File: tb/tb_invader_move_ctl.sv
// Self-checking bench for invader_move_ctl: two instances (default and
// Y_MAX=32) each tracked by a behavioural model, a per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_invader_move_ctl;

  localparam int N   = 10;
  localparam int XS  = 4;
  localparam int XM  = 100;
  localparam int YS  = 16;
  localparam int FPS = 8;

  localparam int P_IDLE = 0;
  localparam int P_R    = 1;
  localparam int P_L    = 2;
  localparam int P_DROP = 3;
  localparam int P_CLR  = 4;
  localparam int P_LAND = 5;

  typedef struct packed {
    int         phase;
    int         x;
    int         y;
    logic [9:0] alive;
    logic       dead;
    logic       landed;
    int         frames;
    logic       go_left;
    logic       vb_prev;
    logic       tick;
  } mdl_t;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] vblnk;
  logic [1:0] start;
  logic [1:0] hit_valid;
  logic [3:0] hit_index [2];
  logic [9:0] xpos [2];
  logic [9:0] ypos [2];
  logic [9:0] en [2];
  logic [1:0] all_dead;
  logic [1:0] reached_bottom;

  mdl_t m [2];
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  invader_move_ctl u_dut_a (
    .clk65MHz(clk), .rst(rst[0]), .vblnk(vblnk[0]), .start(start[0]),
    .hit_valid(hit_valid[0]), .hit_index(hit_index[0]),
    .xpos(xpos[0]), .ypos(ypos[0]), .invader_enable(en[0]),
    .all_dead(all_dead[0]), .reached_bottom(reached_bottom[0]));

  invader_move_ctl #(.Y_MAX(32)) u_dut_b (
    .clk65MHz(clk), .rst(rst[1]), .vblnk(vblnk[1]), .start(start[1]),
    .hit_valid(hit_valid[1]), .hit_index(hit_index[1]),
    .xpos(xpos[1]), .ypos(ypos[1]), .invader_enable(en[1]),
    .all_dead(all_dead[1]), .reached_bottom(reached_bottom[1]));

  function automatic int period_of(input logic [9:0] a);
`ifdef INVADER_SPEEDUP_EN
    int c;
    c = $countones(a);
    if (c > N / 2) return FPS;
    else if (c > 1) return FPS / 2;
    else return FPS / 4;
`else
    return FPS;
`endif
  endfunction

  // One clock of the game rules, written in terms of phases and integers
  function automatic mdl_t next_m(input mdl_t c, input logic r, input logic vb,
                                  input logic st, input logic hv,
                                  input logic [3:0] hi, input int ymax);
    mdl_t       n;
    logic [9:0] left;
    bit         active;
    bit         land;
    int         nxt;
    n = c;
    if (r) begin
      n = '0;
      n.phase = P_IDLE;
      return n;
    end
    n.tick    = vb && !c.vb_prev;
    n.vb_prev = vb;
    left = c.alive;
    if (hv && int'(hi) < N) left[hi] = 1'b0;
    active = (c.phase == P_R) || (c.phase == P_L) || (c.phase == P_DROP);
    if (st && !active) begin
      n.phase = P_R; n.x = 0; n.y = 0; n.alive = 10'h3FF;
      n.dead = 1'b0; n.landed = 1'b0; n.frames = 0; n.go_left = 1'b0;
      return n;
    end
    n.alive = left;
    if (!active) begin
      n.frames = 0;
      return n;
    end
    nxt  = c.phase;
    land = 1'b0;
    if (c.tick) begin
      if (c.frames + 1 >= period_of(c.alive)) begin
        n.frames = 0;
        if (c.phase == P_R) begin
          if (c.x + XS <= XM) n.x = c.x + XS;
          else begin n.x = XM; nxt = P_DROP; n.go_left = 1'b1; end
        end else if (c.phase == P_L) begin
          if (c.x >= XS) n.x = c.x - XS;
          else begin n.x = 0; nxt = P_DROP; n.go_left = 1'b0; end
        end else begin
          if (c.y + YS >= ymax) begin n.y = ymax; nxt = P_LAND; land = 1'b1; end
          else begin n.y = c.y + YS; nxt = c.go_left ? P_L : P_R; end
        end
      end else begin
        n.frames = c.frames + 1;
      end
    end
    if (left == 10'h000) begin
      n.phase = P_CLR;
      n.dead  = 1'b1;
    end else begin
      n.phase = nxt;
      if (land) n.landed = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance both models on the same edge the DUTs sample
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m[d] <= next_m(m[d], rst[d], vblnk[d], start[d], hit_valid[d], hit_index[d],
                     (d == 0) ? 400 : 32);
    end
  end

  // Compare every output of both DUTs against the model, away from the edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("xpos%0d", d), int'(xpos[d]), m[d].x);
        chk($sformatf("ypos%0d", d), int'(ypos[d]), m[d].y);
        chk($sformatf("enable%0d", d), int'(en[d]), int'(m[d].alive));
        chk($sformatf("all_dead%0d", d), int'(all_dead[d]), int'(m[d].dead));
        chk($sformatf("reached_bottom%0d", d), int'(reached_bottom[d]), int'(m[d].landed));
      end
    end
  end

  task automatic frame(input int d);
    vblnk[d] = 1'b1;
    @(negedge clk);
    vblnk[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frame_hit(input int d, input int idx);
    vblnk[d] = 1'b1;
    @(negedge clk);
    vblnk[d] = 1'b0;
    hit_valid[d] = 1'b1;
    hit_index[d] = 4'(idx);
    @(negedge clk);
    hit_valid[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic steps(input int d, input int n);
    repeat (n * FPS) frame(d);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic hit(input int d, input int idx);
    hit_valid[d] = 1'b1;
    hit_index[d] = 4'(idx);
    @(negedge clk);
    hit_valid[d] = 1'b0;
  endtask

  task automatic align_to_step(input int d);
    for (int k = 0; k < 10 && m[d].frames != 0; k++) frame(d);
  endtask

  initial begin
    int x0;
    rst = 2'b11; vblnk = 2'b00; start = 2'b00; hit_valid = 2'b00;
    hit_index[0] = 4'd0; hit_index[1] = 4'd0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_enable", int'(en[0]), 0);
    chk("reset_phase", m[0].phase, P_IDLE);
    rst = 2'b00;
    @(negedge clk);

    // Start a wave, then march
    pulse_start(0);
    chk("start_enable", int'(en[0]), 10'h3FF);
    chk("start_xpos", int'(xpos[0]), 0);
    chk("start_ypos", int'(ypos[0]), 0);
    steps(0, 1);
    chk("step1_xpos", int'(xpos[0]), 4);
    steps(0, 24);
    chk("step25_xpos", int'(xpos[0]), 100);
    steps(0, 1);
    chk("step26_xpos", int'(xpos[0]), 100);
    chk("step26_phase", m[0].phase, P_DROP);
    steps(0, 1);
    chk("step27_ypos", int'(ypos[0]), 16);
    chk("step27_phase", m[0].phase, P_L);
    steps(0, 1);
    chk("step28_xpos", int'(xpos[0]), 96);

    // Hits, including an out-of-range index
    hit(0, 3);
    chk("hit3_enable", int'(en[0]), 10'h3F7);
    hit(0, 12);
    chk("hit12_enable", int'(en[0]), 10'h3F7);

    // Kill the rest, one kill landing on a step
    for (int k = 0; k < 7; k++) frame(0);
    chk("pre_coincide_frames", m[0].frames, 7);
    frame_hit(0, 0);
    chk("coincide_xpos", int'(xpos[0]), 92);
    chk("coincide_enable", int'(en[0]), 10'h3F6);
    hit(0, 1); hit(0, 2); hit(0, 4); hit(0, 5);
    hit(0, 6); hit(0, 7); hit(0, 8);
    chk("one_left_dead", int'(all_dead[0]), 0);
    hit(0, 9);
    chk("cleared_dead", int'(all_dead[0]), 1);
    chk("cleared_phase", m[0].phase, P_CLR);
    steps(0, 2);
    chk("cleared_frozen_x", int'(xpos[0]), 92);
    chk("cleared_frozen_y", int'(ypos[0]), 16);
    pulse_start(0);
    chk("restart_enable", int'(en[0]), 10'h3FF);
    chk("restart_phase", m[0].phase, P_R);

    // Landing with Y_MAX=32, ignored start while marching, reset mid-wave
    pulse_start(1);
    steps(1, 3);
    pulse_start(1);
    chk("ignored_start_x", int'(xpos[1]), 12);
    steps(1, 23);
    chk("b_drop_phase", m[1].phase, P_DROP);
    steps(1, 1);
    chk("b_first_drop_y", int'(ypos[1]), 16);
    steps(1, 26);
    chk("b_second_drop_phase", m[1].phase, P_DROP);
    chk("b_left_edge_x", int'(xpos[1]), 0);
    steps(1, 1);
    chk("land_ypos", int'(ypos[1]), 32);
    chk("land_flag", int'(reached_bottom[1]), 1);
    chk("land_phase", m[1].phase, P_LAND);
    pulse_start(1);
    steps(1, 2);
    hit(1, 2);
    rst[1] = 1'b1;
    vblnk[1] = 1'b1;
    start[1] = 1'b1;
    hit_valid[1] = 1'b1;
    hit_index[1] = 4'd5;
    @(negedge clk);
    rst[1] = 1'b0; vblnk[1] = 1'b0; start[1] = 1'b0; hit_valid[1] = 1'b0;
    chk("midrst_xpos", int'(xpos[1]), 0);
    chk("midrst_ypos", int'(ypos[1]), 0);
    chk("midrst_enable", int'(en[1]), 0);
    chk("midrst_dead", int'(all_dead[1]), 0);
    chk("midrst_bottom", int'(reached_bottom[1]), 0);

`ifdef INVADER_SPEEDUP_EN
    // Five alive: period 4; one alive: period 2
    hit(0, 0); hit(0, 1); hit(0, 2); hit(0, 3); hit(0, 4);
    align_to_step(0);
    x0 = m[0].x;
    repeat (3) frame(0);
    chk("speed5_hold", int'(xpos[0]), x0);
    frame(0);
    chk("speed5_step", int'(xpos[0]), x0 + 4);
    hit(0, 5); hit(0, 6); hit(0, 7); hit(0, 8);
    align_to_step(0);
    x0 = m[0].x;
    frame(0);
    chk("speed1_hold", int'(xpos[0]), x0);
    frame(0);
    chk("speed1_step", int'(xpos[0]), x0 + 4);
`else
    x0 = 0;
`endif

    // Random traffic on both instances
    for (int it = 0; it < 3000; it++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 2) == 0) vblnk[d] = ~vblnk[d];
        start[d]     = ($urandom_range(0, 60) == 0);
        hit_valid[d] = ($urandom_range(0, 39) == 0);
        hit_index[d] = 4'($urandom_range(0, 15));
        rst[d]       = ($urandom_range(0, 700) == 0);
      end
      @(negedge clk);
    end
    rst = 2'b00; vblnk = 2'b00; start = 2'b00; hit_valid = 2'b00;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/invader_move_ctl.md
INVADER_MOVE_CTL -- requirements
Module: invader_move_ctl

Interface
REQ-001 The block SHALL have the following parameters:
- NUM_INVADERS, 10, number of invaders in the row.
- X_STEP, 4, horizontal pixels per march step.
- X_MAX, 100, largest xpos value.
- Y_STEP, 16, vertical pixels per drop.
- Y_MAX, 400, ypos value that counts as landed.
- FRAMES_PER_STEP, 8, frames between steps; a power of two, at least 4.

REQ-002 The block SHALL have the following ports (clock and reset first):
- clk65MHz  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- vblnk  in  1  vertical blank from the timing stage.
- start  in  1  one-cycle pulse that starts a new wave.
- hit_valid  in  1  one-cycle pulse: an invader has been hit.
- hit_index  in  4  index of the hit invader.
- xpos  out  10  row x offset.
- ypos  out  10  row y offset.
- invader_enable  out  NUM_INVADERS  alive mask; bit i is invader i.
- all_dead  out  1  the wave is cleared.
- reached_bottom  out  1  the row has landed.

REQ-003 All outputs SHALL be registered and SHALL change only on the rising edge of clk65MHz.

Function
REQ-004 A frame tick SHALL be a one-cycle internal pulse, asserted on the cycle after a 0->1 transition of vblnk is sampled.
REQ-005 The state machine SHALL have the states IDLE, MARCH_R, MARCH_L, DROP, CLEARED and LANDED.
REQ-006 In MARCH_R, MARCH_L and DROP, a frame counter SHALL count ticks; a step SHALL occur on the tick that makes the count equal the step period; the counter SHALL then return to 0.
REQ-007 MARCH_R step: if xpos+X_STEP <= X_MAX, add X_STEP to xpos; otherwise hold xpos at X_MAX and go to DROP, recording the next direction as left.
REQ-008 MARCH_L step: if xpos >= X_STEP, subtract X_STEP from xpos; otherwise set xpos to 0 and go to DROP, recording the next direction as right.
REQ-009 DROP step: if ypos+Y_STEP >= Y_MAX, set ypos to Y_MAX, go to LANDED and set reached_bottom; otherwise add Y_STEP to ypos and go to the recorded direction.
REQ-010 A hit SHALL clear invader_enable[hit_index] on the next edge, in any state; a hit_index >= NUM_INVADERS SHALL be ignored; a hit on a bit that is already clear SHALL have no effect.
REQ-011 A hit and a step in the same cycle SHALL both take effect.
REQ-012 When invader_enable becomes all-zero while marching or dropping, the next state SHALL be CLEARED with all_dead=1; this SHALL take priority over a same-cycle landing.
REQ-013 start in IDLE, CLEARED or LANDED SHALL set xpos=0, ypos=0, invader_enable to all ones, the frame counter to 0, all_dead=0 and reached_bottom=0, and the state to MARCH_R; start in any other state SHALL be ignored.
REQ-014 In IDLE, CLEARED and LANDED, xpos and ypos SHALL hold their values and the frame counter SHALL stay at 0.
REQ-015 Position arithmetic SHALL be done 11 bits wide, so the results never wrap.

Reset
REQ-016 When rst=1, the block SHALL set xpos=0, ypos=0, invader_enable=0, all_dead=0, reached_bottom=0, frame counter=0, direction=right and state=IDLE.
REQ-017 Reset SHALL override start, hit_valid and any tick in the same cycle, including when it is asserted mid-wave.

Configuration
REQ-018 With INVADER_SPEEDUP_EN defined, the step period SHALL be:
- FRAMES_PER_STEP while alive count > NUM_INVADERS/2;
- FRAMES_PER_STEP/2 while alive count > 1;
- FRAMES_PER_STEP/4 otherwise.
REQ-019 A change of step period SHALL take effect from the next counter comparison; if the counter is already >= the new period, the step SHALL occur on the next tick.
REQ-020 Without INVADER_SPEEDUP_EN, the step period SHALL always be FRAMES_PER_STEP, and no popcount logic SHALL be instantiated.

Structure
REQ-021 The package invader_pkg SHALL hold the state enum type invader_state_t and the default step constants.
REQ-022 The sub-module invader_popcount, parameterised by width, SHALL compute the alive count; it SHALL be instantiated only under INVADER_SPEEDUP_EN.

Verification
REQ-023 The bench SHALL cover these directed scenarios, using default parameters unless stated:
- Reset, then start -> invader_enable=10'h3FF, xpos=0, ypos=0; after 8 vblnk rises, xpos=4.
- 25 steps -> xpos=100; step 26 -> state DROP, xpos=100; step 27 -> ypos=16, state MARCH_L; step 28 -> xpos=96.
- hit_index=3 -> invader_enable=10'h3F7 on the next edge; then hit_index=12 -> invader_enable unchanged.
- Hit all 10 invaders, including one hit coinciding with a step -> all_dead=1, state CLEARED, positions frozen; start -> 10'h3FF, state MARCH_R.
- Y_MAX=32: the second DROP step -> ypos=32, reached_bottom=1, state LANDED; start during MARCH_R is ignored; rst asserted mid-wave -> all outputs equal the REQ-016 values.
- INVADER_SPEEDUP_EN defined: 5 alive -> a step every 4 frames; 1 alive -> a step every 2 frames.
